tick_interval_timer: RTL and testbench
======================================

// Module: tick_interval_timer
// PURPOSE
//   Programmable down-timer driven by the carry pulse of the upstream mod-N
//   prescaler counter: counts `tick` strobes (one-cycle carry pulses) and
//   flags expiry after LOAD ticks. Supports one-shot or auto-reload periodic
//   mode. Sits directly downstream of the prescaler and produces timeout
//   pulses for control FSMs.
// PARAMETERS
//   CNT_W   8   width of load value / remaining-tick counter
// PORTS
//   clk        in   1      system clock, all state on posedge
//   clr_n      in   1      reset, asynchronous assert, active-low
//   tick       in   1      carry pulse from prescaler; 1 = one tick elapsed
//   start      in   1      1-cycle request: latch load_val/auto_reload, begin timing
//   abort      in   1      1-cycle request: stop timing, return to IDLE
//   load_val   in   CNT_W  ticks to expiry; sampled only on accepted start
//   auto_rel   in   1      sampled with start; 1 = periodic mode
//   busy       out  1      1 while state == RUN
//   expired    out  1      registered 1-cycle pulse on each expiry
//   remaining  out  CNT_W  ticks left before expiry (0 in IDLE)
//   overrun    out  1      sticky; set if start arrives while RUN; cleared by abort
// BEHAVIOUR
//   Reset (clr_n=0, async): state=IDLE, busy=0, expired=0, remaining=0,
//     overrun=0, reload register=0, mode=one-shot.
//   States: IDLE, RUN. All outputs registered; no combinational paths in->out.
//   IDLE: start=1 & load_val!=0 -> RUN, remaining<=load_val, reload<=load_val,
//     mode<=auto_rel. start=1 & load_val==0 -> stay IDLE, expired=1 next cycle.
//     tick ignored in IDLE.
//   RUN: tick=1 & remaining>1 -> remaining-1.
//     tick=1 & remaining==1 -> expired=1 next cycle; periodic: remaining<=reload,
//     stay RUN; one-shot: remaining<=0, -> IDLE.
//   Latency: expired asserts the cycle after the tick that takes remaining 1->0.
//   Priority in any state: abort > start > tick.
//     abort: -> IDLE, remaining<=0, overrun<=0, no expired pulse even if the
//       same-cycle tick would expire.
//     start in RUN: restart with new load_val/auto_rel, overrun<=1, the
//       same-cycle tick is discarded, no expired.
//   remaining never wraps: decrement only when remaining>=1.
//   tick held high for consecutive cycles counts once per cycle (no edge detect).
//   Reset mid-RUN: immediate return to reset values; no pulse emitted.
// STRUCTURE
//   tick_timer_pkg: typedef enum logic {IDLE, RUN} tmr_state_t; no other
//     shared constants.
//   Single module, no sub-modules: one always_ff (state, counter, flags),
//     one always_comb next-state.
// TESTING
//   1 one-shot: load_val=3, auto_rel=0, start; 3 ticks spaced 5 clks ->
//     remaining 3,2,1,0; expired 1 clk after 3rd tick; busy drops same cycle.
//   2 periodic: load_val=2, auto_rel=1, 6 ticks -> expired after ticks 2,4,6;
//     busy stays 1; remaining reloads to 2 each time.
//   3 zero load: start with load_val=0 -> expired next cycle, busy never 1.
//   4 abort vs expiry: remaining=1, tick & abort same cycle -> no expired,
//     IDLE, remaining=0.
//   5 restart: RUN remaining=4, start load_val=7 with tick -> remaining=7,
//     overrun=1; later abort clears overrun.
//   6 async reset mid-RUN: drop clr_n between clk edges -> all outputs 0
//     immediately; ticks ignored until a new start.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// Shared types for the tick interval timer.
package tick_timer_pkg;

   typedef enum logic {IDLE, RUN} tmr_state_t;

endpackage

// File: rtl/tick_interval_timer_if.sv
// Request/status bundle between a control FSM (master) and the tick interval timer (slave).
interface tick_interval_timer_if #(
   parameter int CNT_W = 8
);
   logic             tick;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] load_val;
   logic             auto_rel;
   logic             busy;
   logic             expired;
   logic [CNT_W-1:0] remaining;
   logic             overrun;

   modport master (
      output tick, start, abort, load_val, auto_rel,
      input  busy, expired, remaining, overrun
   );

   modport slave (
      input  tick, start, abort, load_val, auto_rel,
      output busy, expired, remaining, overrun
   );
endinterface

// File: rtl/tick_interval_timer.sv
// Programmable down-timer counting prescaler carry pulses; one-shot or auto-reload,
// emits a registered one-cycle expiry pulse. Request priority: abort > start > tick.
module tick_interval_timer
   import tick_timer_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 clr_n,
   tick_interval_timer_if.slave tmr
);

   tmr_state_t       state_reg, state_next;
   logic [CNT_W-1:0] remaining_reg, remaining_next;
   logic [CNT_W-1:0] reload_reg, reload_next;
   logic             periodic_reg, periodic_next;
   logic             expired_reg, expired_next;
   logic             overrun_reg, overrun_next;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_reg     <= IDLE;
         remaining_reg <= '0;
         reload_reg    <= '0;
         periodic_reg  <= 1'b0;
         expired_reg   <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         reload_reg    <= reload_next;
         periodic_reg  <= periodic_next;
         expired_reg   <= expired_next;
         overrun_reg   <= overrun_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      reload_next    = reload_reg;
      periodic_next  = periodic_reg;
      expired_next   = 1'b0;
      overrun_next   = overrun_reg;

      if (tmr.abort) begin
         // Abort swallows any same-cycle expiry.
         state_next     = IDLE;
         remaining_next = '0;
         overrun_next   = 1'b0;
      end else if (tmr.start) begin
         if (state_reg == RUN) begin
            overrun_next = 1'b1;
         end
         if (tmr.load_val != '0) begin
            state_next     = RUN;
            remaining_next = tmr.load_val;
            reload_next    = tmr.load_val;
            periodic_next  = tmr.auto_rel;
         end else begin
            // A zero-length interval expires at once without entering RUN.
            state_next     = IDLE;
            remaining_next = '0;
            expired_next   = 1'b1;
         end
      end else if (tmr.tick && (state_reg == RUN)) begin
         if (remaining_reg > CNT_W'(1)) begin
            remaining_next = remaining_reg - CNT_W'(1);
         end else if (remaining_reg == CNT_W'(1)) begin
            expired_next = 1'b1;
            if (periodic_reg) begin
               remaining_next = reload_reg;
            end else begin
               remaining_next = '0;
               state_next     = IDLE;
            end
         end
      end
   end

   assign tmr.busy      = (state_reg == RUN);
   assign tmr.expired   = expired_reg;
   assign tmr.remaining = remaining_reg;
   assign tmr.overrun   = overrun_reg;

endmodule

// File: tb/tb_tick_interval_timer.sv
// Scoreboard bench for tick_interval_timer: stimulus queues expected status and expiry
// cycles, an independent monitor checks them after every clock edge.
module tb_tick_interval_timer;

   typedef struct {
      string      name;
      logic       busy;
      logic       expired;
      logic [7:0] remaining;
      logic       overrun;
   } status_t;

   logic    clk = 1'b0;
   logic    clr_n = 1'b0;
   int      checks = 0;
   int      errors = 0;
   int      cyc = 0;
   status_t chk_q[$];
   int      exp_q[$];

   tick_interval_timer_if #(.CNT_W(8)) bus ();

   tick_interval_timer #(.CNT_W(8)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .tmr   (bus.slave)
   );

   always #5 clk = ~clk;

   // Drive one cycle of requests on the falling edge.
   task automatic drive(input logic t, input logic s, input logic a,
                        input logic [7:0] lv, input logic ar);
      @(negedge clk);
      bus.tick     = t;
      bus.start    = s;
      bus.abort    = a;
      bus.load_val = lv;
      bus.auto_rel = ar;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
   endtask

   // Expected status after the coming rising edge.
   task automatic chk(input string nm, input logic b, input logic e,
                      input logic [7:0] r, input logic o);
      status_t s;
      s.name = nm; s.busy = b; s.expired = e; s.remaining = r; s.overrun = o;
      chk_q.push_back(s);
   endtask

   task automatic expect_expiry();
      exp_q.push_back(cyc + 1);
   endtask

   // Monitor: samples 2 time units after each rising edge.
   initial begin
      status_t s;
      int      c;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (bus.expired) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_expiry: expired=1 at cycle %0d, required no pulse", cyc);
            end else begin
               c = exp_q.pop_front();
               if (c != cyc) begin
                  errors++;
                  $display("FAIL expiry_cycle: pulse at cycle %0d, required cycle %0d", cyc, c);
               end else begin
                  $display("expiry at cycle %0d ok", cyc);
               end
            end
         end
         while (exp_q.size() > 0 && exp_q[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_expiry: no pulse at cycle %0d, required expired=1", exp_q[0]);
            void'(exp_q.pop_front());
         end
         while (chk_q.size() > 0) begin
            s = chk_q.pop_front();
            checks++;
            if (bus.busy !== s.busy || bus.expired !== s.expired ||
                bus.remaining !== s.remaining || bus.overrun !== s.overrun) begin
               errors++;
               $display("FAIL %s: busy=%b exp=%b rem=%0d ovr=%b, required busy=%b exp=%b rem=%0d ovr=%b",
                        s.name, bus.busy, bus.expired, bus.remaining, bus.overrun,
                        s.busy, s.expired, s.remaining, s.overrun);
            end else begin
               $display("cycle %0d %s ok", cyc, s.name);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.tick = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
      bus.load_val = 8'd0; bus.auto_rel = 1'b0;

      idle(1);
      chk("reset_state", 1'b0, 1'b0, 8'd0, 1'b0);
      idle(1);
      @(negedge clk);
      clr_n = 1'b1;

      // One-shot, load 3, ticks spaced 5 clocks.
      drive(1'b0, 1'b1, 1'b0, 8'd3, 1'b0); chk("os_start", 1'b1, 1'b0, 8'd3, 1'b0);
      idle(4);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0); chk("os_tick1", 1'b1, 1'b0, 8'd2, 1'b0);
      idle(4);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0); chk("os_tick2", 1'b1, 1'b0, 8'd1, 1'b0);
      idle(4);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0); expect_expiry();
      chk("os_expire", 1'b0, 1'b1, 8'd0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0); chk("os_idle_tick", 1'b0, 1'b0, 8'd0, 1'b0);

      // Periodic, load 2, tick held high for 6 cycles.
      drive(1'b0, 1'b1, 1'b0, 8'd2, 1'b1); chk("per_start", 1'b1, 1'b0, 8'd2, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
         if (i % 2 == 0) begin
            expect_expiry();
            chk("per_reload", 1'b1, 1'b1, 8'd2, 1'b0);
         end else begin
            chk("per_count", 1'b1, 1'b0, 8'd1, 1'b0);
         end
      end
      drive(1'b0, 1'b0, 1'b1, 8'd0, 1'b0); chk("per_abort", 1'b0, 1'b0, 8'd0, 1'b0);

      // Zero load expires immediately without entering RUN.
      drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0); expect_expiry();
      chk("zero_load", 1'b0, 1'b1, 8'd0, 1'b0);
      idle(1); chk("zero_after", 1'b0, 1'b0, 8'd0, 1'b0);

      // Abort wins over a same-cycle expiring tick.
      drive(1'b0, 1'b1, 1'b0, 8'd1, 1'b0); chk("ab_start", 1'b1, 1'b0, 8'd1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 8'd0, 1'b0); chk("ab_vs_tick", 1'b0, 1'b0, 8'd0, 1'b0);
      idle(2); chk("ab_quiet", 1'b0, 1'b0, 8'd0, 1'b0);

      // Restart while running discards the tick and sets overrun.
      drive(1'b0, 1'b1, 1'b0, 8'd4, 1'b0); chk("rs_start", 1'b1, 1'b0, 8'd4, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'd7, 1'b0); chk("rs_restart", 1'b1, 1'b0, 8'd7, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0); chk("rs_tick", 1'b1, 1'b0, 8'd6, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 8'd0, 1'b0); chk("rs_abort_clr", 1'b0, 1'b0, 8'd0, 1'b0);

      // Restart on the would-be expiring tick suppresses the pulse.
      drive(1'b0, 1'b1, 1'b0, 8'd2, 1'b0); chk("rs2_start", 1'b1, 1'b0, 8'd2, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0); chk("rs2_tick", 1'b1, 1'b0, 8'd1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'd5, 1'b0); chk("rs2_restart", 1'b1, 1'b0, 8'd5, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0); chk("rs2_tick2", 1'b1, 1'b0, 8'd4, 1'b1);
      idle(1); chk("rs2_hold", 1'b1, 1'b0, 8'd4, 1'b1);

      // Asynchronous reset between clock edges.
      @(negedge clk);
      #2 clr_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.expired !== 1'b0 || bus.remaining !== 8'd0 || bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: busy=%b exp=%b rem=%0d ovr=%b, required all 0",
                  bus.busy, bus.expired, bus.remaining, bus.overrun);
      end else begin
         $display("async reset outputs cleared ok");
      end
      @(negedge clk);
      clr_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0); chk("post_reset_tick", 1'b0, 1'b0, 8'd0, 1'b0);
      end
      drive(1'b0, 1'b1, 1'b0, 8'd1, 1'b0); chk("post_reset_start", 1'b1, 1'b0, 8'd1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0); expect_expiry();
      chk("post_reset_expire", 1'b0, 1'b1, 8'd0, 1'b0);

      idle(3);
      while (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL pending_expiry: no pulse seen, required one at cycle %0d", exp_q[0]);
         void'(exp_q.pop_front());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
